// File: rtl/muldiv_unit_pkg.sv
// Shared op codes for the multiply/divide unit, alongside the ALU op space.
// Optional divide datapath is enabled with MULDIV_DIV_EN.
package muldiv_unit_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    function automatic logic md_is_mul(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic md_is_signed(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the muldiv unit.
interface muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [WIDTH-1:0] req_x;
    logic [WIDTH-1:0] req_y;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output req_valid, req_op, req_x, req_y,
        input  req_ready, hi, lo, busy, done, div_by_zero
    );

    modport slave (
        input  req_valid, req_op, req_x, req_y,
        output req_ready, hi, lo, busy, done, div_by_zero
    );
endinterface

// File: rtl/muldiv_iter.sv
// Unsigned shift-add multiply / restoring divide engine, WIDTH iterations per op.
// Divide step is present only when MULDIV_DIV_EN is defined.
module muldiv_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               div_mode,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic [2*WIDTH-1:0] result,
    output logic               last
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH:0]     sum;

`ifdef MULDIV_DIV_EN
    logic div_q;

    always_ff @(posedge clk) begin
        if (!rst_n)     div_q <= 1'b0;
        else if (start) div_q <= div_mode;
    end
`else
    logic unused_div;
    assign unused_div = div_mode;
`endif

    // Mul: acc = {partial, multiplier}, shift right. Div: acc = {rem, dividend/quot}, shift left.
    always_comb begin
        sum   = '0;
        acc_d = acc_q;
`ifdef MULDIV_DIV_EN
        if (div_q) begin
            sum = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
            if (sum[WIDTH]) acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
            else            acc_d = {sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else
`endif
        begin
            sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
            acc_d = {sum, acc_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q  <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
        end else if (start) begin
            acc_q  <= {{WIDTH{1'b0}}, (div_mode ? op_a : op_b)};
            opnd_q <= div_mode ? op_b : op_a;
            cnt_q  <= CW'(WIDTH);
        end else if (cnt_q != '0) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign result = acc_q;
    assign last   = (cnt_q == CW'(1));

endmodule

// File: rtl/muldiv_unit.sv
// MIPS HI/LO multiply/divide unit: FSM, handshake, sign handling and HI/LO.
// DIV/DIVU are supported only when MULDIV_DIV_EN is defined.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    muldiv_unit_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e             state_q, state_d;
    logic               accept, op_mul, op_div, op_signed, y_zero, use_iter;
    logic [WIDTH-1:0]   mag_x, mag_y, hi_q, lo_q;
    logic [2*WIDTH-1:0] iter_result, commit;
    logic               iter_last, div_q, neg_lo_q, neg_hi_q, done_q, dbz_q;

    assign accept    = bus.req_valid && (state_q == StIdle);
    assign op_mul    = md_is_mul(bus.req_op);
    assign op_signed = md_is_signed(bus.req_op);
    assign y_zero    = (bus.req_y == '0);
`ifdef MULDIV_DIV_EN
    assign op_div = (bus.req_op == MD_DIV) || (bus.req_op == MD_DIVU);
`else
    assign op_div = 1'b0;
`endif
    assign use_iter = accept && (op_mul || (op_div && !y_zero));

    assign mag_x = (op_signed && bus.req_x[WIDTH-1]) ? -bus.req_x : bus.req_x;
    assign mag_y = (op_signed && bus.req_y[WIDTH-1]) ? -bus.req_y : bus.req_y;

    muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (use_iter),
        .div_mode (op_div),
        .op_a     (mag_x),
        .op_b     (mag_y),
        .result   (iter_result),
        .last     (iter_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (use_iter) state_d = StCalc;
            StCalc:  if (iter_last) state_d = StFix;
            StFix:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.busy      = (state_q != StIdle);
        bus.req_ready = (state_q == StIdle);
    end

    // Div negates quotient and remainder independently; mul negates the whole product.
    always_comb begin
        commit = iter_result;
        if (div_q) begin
            commit[WIDTH-1:0]       = neg_lo_q ? -iter_result[WIDTH-1:0] : iter_result[WIDTH-1:0];
            commit[2*WIDTH-1:WIDTH] = neg_hi_q ? -iter_result[2*WIDTH-1:WIDTH]
                                               : iter_result[2*WIDTH-1:WIDTH];
        end else if (neg_lo_q) begin
            commit = -iter_result;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            div_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
        end else begin
            done_q <= (accept && !use_iter) || (state_q == StFix);
            dbz_q  <= accept && op_div && y_zero;
            if (use_iter) begin
                div_q    <= op_div;
                neg_lo_q <= op_signed && (bus.req_x[WIDTH-1] ^ bus.req_y[WIDTH-1]);
                neg_hi_q <= op_signed && bus.req_x[WIDTH-1];
            end
            if (accept && (bus.req_op == MD_MTHI)) hi_q <= bus.req_x;
            if (accept && (bus.req_op == MD_MTLO)) lo_q <= bus.req_x;
            if (state_q == StFix) {hi_q, lo_q} <= commit;
        end
    end

    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;

endmodule
